kth_largest_stream: RTL

- Streaming order-statistic tracker and parametrised successor of the second-largest block.
- Holds the DEPTH largest samples seen since reset/clear in a descending sorted register array, with one insertion per clock.
- Any rank 0..DEPTH-1 is selectable at run time. Supports a valid qualifier, a synchronous clear, and signed or unsigned comparison.
- Sits on a sample stream feeding peak/threshold logic.

---
 rtl/kth_largest_stream_if.sv | 27 ++
 rtl/kth_largest_stream.sv | 66 ++++++
 2 files changed

// File: rtl/kth_largest_stream_if.sv
// Sample stream interface for kth_largest_stream: sample input, rank select, and the selected-rank result.
// A sample is accepted on every rising edge where din_valid is high. There is no ready signal, so every valid sample is taken.
interface kth_largest_stream_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
);
    localparam int RW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic             din_valid;
    logic [WIDTH-1:0] din;
    logic             clear;
    logic [RW-1:0]    rank_sel;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic [CW-1:0]    count;

    modport master (
        output din_valid, din, clear, rank_sel,
        input  dout, dout_valid, count
    );

    modport slave (
        input  din_valid, din, clear, rank_sel,
        output dout, dout_valid, count
    );
endinterface

// File: rtl/kth_largest_stream.sv
// Tracks the DEPTH largest samples seen since reset/clear in a descending sorted register array.
// Inserts one sample per clock and returns the value at a run-time selected rank.
module kth_largest_stream #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 4,
    parameter bit SIGNED = 1'b0
) (
    input logic                 clk,
    input logic                 resetn,
    kth_largest_stream_if.slave bus
);
    localparam int RW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] top     [DEPTH];
    logic [WIDTH-1:0] top_nxt [DEPTH];
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic [DEPTH-1:0] keep;
    logic [WIDTH-1:0] sel;
    logic             sel_valid;

    function automatic logic ge(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (SIGNED) return $signed(a) >= $signed(b);
        else        return a >= b;
    endfunction

    // An occupied entry stays put when it is >= din, so equal values keep their place above the new sample.
    // Because the array is sorted, keep is a prefix and its first zero marks the insertion slot.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            keep[i] = (CW'(i) < count) && ge(top[i], bus.din);
        end
        top_nxt[0] = keep[0] ? top[0] : bus.din;
        for (int i = 1; i < DEPTH; i++) begin
            if (keep[i])          top_nxt[i] = top[i];
            else if (keep[i-1])   top_nxt[i] = bus.din;
            else                  top_nxt[i] = top[i-1];
        end
        count_nxt = (count == CW'(DEPTH)) ? count : count + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!resetn || bus.clear) begin
            for (int i = 0; i < DEPTH; i++) top[i] <= '0;
            count <= '0;
        end else if (bus.din_valid) begin
            // When keep is all ones the array is full and din is too small, so next state equals current state.
            for (int i = 0; i < DEPTH; i++) top[i] <= top_nxt[i];
            count <= count_nxt;
        end
    end

    // Out-of-range rank values never match any entry, so they fall through to zero/invalid.
    always_comb begin
        sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.rank_sel == RW'(i)) sel = top[i];
        end
        sel_valid = 32'(count) > 32'(bus.rank_sel);
    end

    assign bus.dout_valid = sel_valid;
    assign bus.dout       = sel_valid ? sel : '0;
    assign bus.count      = count;
endmodule
